spi_arbiter: RTL
================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter W, default 8: width of the per-requester clock-divider word.
REQ-002 Parameter TIMEOUT, default 255: WAIT-state cycle limit, used only when SPI_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  per-requester request level, bit i = requester i; held high until its ack.
REQ-006 div_in  input  4*W  per-requester divider, bits [i*W +: W] = requester i.
REQ-007 tx_data  input  32  per-requester transmit byte, bits [i*8 +: 8] = requester i.
REQ-008 ack  output  4  one-cycle completion pulse, bit i = requester i.
REQ-009 rx_data  output  8  received byte, valid only in the ack cycle.
REQ-010 err  output  1  timeout flag, valid only in the ack cycle.
REQ-011 grant  output  4  one-hot owner of the engine, zero when idle.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 eng_start  output  1  one-cycle start pulse to the serial engine.
REQ-014 eng_div  output  W  divider to engine, stable from eng_start until ack.
REQ-015 eng_tx  output  8  transmit byte to engine, stable from eng_start until ack.
REQ-016 eng_done  input  1  one-cycle pulse from engine when cs_n returns high.
REQ-017 eng_rx  input  8  engine receive byte, valid with eng_done.

Function
REQ-018 FSM states: IDLE, START, WAIT, RESP; all outputs registered.
REQ-019 IDLE: if any req bit is set, select the winner, register grant, eng_div and eng_tx from the winner's slices, and go to START; otherwise stay.
REQ-020 Round-robin: search begins at bit (ptr+1) mod 4 and wraps; ptr updates to the winner index in RESP.
REQ-021 START: eng_start=1 for exactly this cycle, then go to WAIT.
REQ-022 WAIT: on eng_done=1, capture eng_rx into rx_data and go to RESP.
REQ-023 RESP: ack[winner]=1 and rx_data/err valid for one cycle; then grant=0 and return to IDLE.
REQ-024 Latency: req seen in IDLE at cycle T -> grant and eng_start at T+1 -> eng_done at D -> ack at D+1; minimum req-to-ack is 3 cycles.
REQ-025 Deassertion of req[winner] after grant is ignored; the transaction completes and ack is still issued.
REQ-026 req changes in the other bits during START/WAIT/RESP are ignored until the next IDLE.
REQ-027 eng_done outside WAIT is ignored.
REQ-028 A requester that keeps req high after ack is treated as a new request in the following IDLE cycle, subject to round-robin order.
REQ-029 rx_data holds its last value outside ack cycles; err is 0 outside ack cycles.
REQ-030 At most one ack bit is high in any cycle, and an ack bit is high only when the matching grant bit is also high.

Reset
REQ-031 On rst_n low, asynchronously: state=IDLE, ptr=3 (requester 0 wins first), and grant, ack, rx_data, err, busy, eng_start, eng_div and eng_tx all become 0.
REQ-032 If reset is asserted mid-transaction, the transaction is abandoned with no ack, and eng_start is deasserted immediately.
REQ-033 After rst_n rises, the first arbitration occurs on the first clock edge at which any req bit is set.

Configuration
REQ-034 Macro SPI_ARB_TIMEOUT_EN defined: a WAIT cycle counter clears on entry to WAIT; if it reaches TIMEOUT without eng_done, go to RESP with err=1 and rx_data=0.
REQ-035 With SPI_ARB_TIMEOUT_EN defined, if eng_done and the timeout terminal count occur in the same cycle, eng_done wins and err=0.
REQ-036 Macro SPI_ARB_TIMEOUT_EN undefined: there is no counter, WAIT holds indefinitely, and err is tied to 0.

Verification
REQ-037 req=0001, div_in[0]=3, tx_data[0]=0xA5, eng_done 5 cycles after eng_start with eng_rx=0x3C -> eng_div=3, eng_tx=0xA5, then ack=0001 with rx_data=0x3C and err=0.
REQ-038 req=1111 held constantly after reset -> grant order 0,1,2,3,0, with exactly one ack per transaction.
REQ-039 req=0100 dropped one cycle after grant -> the transaction completes and ack=0100 is still issued.
REQ-040 rst_n pulsed low during WAIT -> all outputs are 0 immediately, no ack is issued, and the next req=0010 is granted normally.
REQ-041 With SPI_ARB_TIMEOUT_EN defined, TIMEOUT=10 and eng_done never asserted -> ack 11 cycles after entering WAIT, with err=1 and rx_data=0x00.
REQ-042 eng_done pulsed while in IDLE -> no state change and no ack.

Source files
------------

// File: rtl/spi_arbiter_if.sv
// Bus bundle between the SPI arbiter, its four requesters and the serial engine.
// slave = arbiter side, master = requester/engine side.
interface spi_arbiter_if #(
    parameter int W = 8
);
    logic [3:0]     req;
    logic [4*W-1:0] div_in;
    logic [31:0]    tx_data;
    logic [3:0]     ack;
    logic [7:0]     rx_data;
    logic           err;
    logic [3:0]     grant;
    logic           busy;
    logic           eng_start;
    logic [W-1:0]   eng_div;
    logic [7:0]     eng_tx;
    logic           eng_done;
    logic [7:0]     eng_rx;

    modport slave (
        input  req, div_in, tx_data, eng_done, eng_rx,
        output ack, rx_data, err, grant, busy, eng_start, eng_div, eng_tx
    );

    modport master (
        output req, div_in, tx_data, eng_done, eng_rx,
        input  ack, rx_data, err, grant, busy, eng_start, eng_div, eng_tx
    );
endinterface

// File: rtl/spi_arbiter.sv
// Four-requester round-robin arbiter in front of a single SPI serial engine.
// Optional WAIT-state watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] owner;
    logic [1:0] win;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CW-1:0] cnt;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT != 0);
`endif

    // Scan from ptr+1 upward; iterating backwards lets the nearest request win.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int unsigned k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb win = rr_pick(bus.req, ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= 2'd3;
            owner         <= 2'd0;
            bus.grant     <= '0;
            bus.ack       <= '0;
            bus.rx_data   <= '0;
            bus.err       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.eng_start <= 1'b0;
            bus.eng_div   <= '0;
            bus.eng_tx    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner         <= win;
                        bus.grant     <= 4'b0001 << win;
                        bus.eng_div   <= bus.div_in[win*W +: W];
                        bus.eng_tx    <= bus.tx_data[win*8 +: 8];
                        bus.eng_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= START;
                    end
                end
                START: begin
                    bus.eng_start <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
                    cnt           <= '0;
`endif
                    state         <= WAIT;
                end
                WAIT: begin
                    // A completing engine takes priority over an expiring watchdog.
                    if (bus.eng_done) begin
                        bus.rx_data <= bus.eng_rx;
                        bus.err     <= 1'b0;
                        bus.ack     <= bus.grant;
                        state       <= RESP;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT)) begin
                        bus.rx_data <= '0;
                        bus.err     <= 1'b1;
                        bus.ack     <= bus.grant;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    bus.ack   <= '0;
                    bus.err   <= 1'b0;
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                    ptr       <= owner;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
